ndp_reset_sequencer: RTL and testbench

Board-level reset sequencer for the NDP NetFPGA design: the in-fabric counterpart of the bench's reset and clock stimulus. It consumes the board reset and the clock-tree/PCIe lock indications. After a programmable hold it releases staged active-low resets in a fixed order: register block, then core logic, then the NDP datapath. It also drives a heartbeat LED once the datapath is running.

---
 rtl/ndp_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ndp_reset_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ndp_reset_sequencer.sv
// Staged active-low reset release (reg -> core -> datapath) after stable lock.
// Optional heartbeat counter on led_heartbeat: NDP_RST_SEQ_HEARTBEAT_EN.
module ndp_reset_sequencer #(
    parameter int HOLD_CYCLES = 200,
    parameter int STAGE_GAP   = 16,
    parameter int HB_DIV_LOG2 = 24
) (
    input  logic axis_aclk,
    input  logic axis_resetn,
    input  logic clk_locked,
    input  logic pcie_link_up,
    input  logic sw_reset_req,
    output logic reg_resetn,
    output logic core_resetn,
    output logic dp_resetn,
    output logic seq_done,
    output logic led_heartbeat
);

    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    if (HOLD_CYCLES < 1 || STAGE_GAP < 1 || HB_DIV_LOG2 < 1) begin : g_bad_cfg
        $error("ndp_reset_sequencer: parameters must all be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_REL_REG,
        S_REL_CORE,
        S_RUN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          lk_s1;
    logic          lk_s2;
    logic          lu_s1;
    logic          lu_s2;
    logic          lock_ok;
    logic          abort;
    logic          reg_d;
    logic          core_d;
    logic          dp_d;

    // Lock pins are asynchronous; two flops each before use
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            lk_s1 <= 1'b0;
            lk_s2 <= 1'b0;
            lu_s1 <= 1'b0;
            lu_s2 <= 1'b0;
        end else begin
            lk_s1 <= clk_locked;
            lk_s2 <= lk_s1;
            lu_s1 <= pcie_link_up;
            lu_s2 <= lu_s1;
        end
    end

    assign lock_ok = lk_s2 & lu_s2;
    assign abort   = (state != S_IDLE) && (!lock_ok || sw_reset_req);

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            reg_resetn  <= 1'b0;
            core_resetn <= 1'b0;
            dp_resetn   <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            reg_resetn  <= reg_d;
            core_resetn <= core_d;
            dp_resetn   <= dp_d;
            seq_done    <= dp_d;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (lock_ok) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    next_state = S_REL_REG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_REL_REG: begin
                if (cnt == GAP_LAST) begin
                    next_state = S_REL_CORE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_REL_CORE: begin
                if (cnt == GAP_LAST) begin
                    next_state = S_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_RUN: begin
                cnt_next = '0;
            end
            default: begin
                next_state = S_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Abort wins over any terminal count on the same edge
        if (abort) begin
            next_state = S_IDLE;
            cnt_next   = '0;
        end
    end

    // Reset levels follow the state being entered, so they are registered
    always_comb begin
        reg_d  = 1'b0;
        core_d = 1'b0;
        dp_d   = 1'b0;
        unique case (next_state)
            S_REL_REG: begin
                reg_d = 1'b1;
            end
            S_REL_CORE: begin
                reg_d  = 1'b1;
                core_d = 1'b1;
            end
            S_RUN: begin
                reg_d  = 1'b1;
                core_d = 1'b1;
                dp_d   = 1'b1;
            end
            default: begin
                reg_d  = 1'b0;
                core_d = 1'b0;
                dp_d   = 1'b0;
            end
        endcase
    end

`ifdef NDP_RST_SEQ_HEARTBEAT_EN
    logic [HB_DIV_LOG2-1:0] hb_cnt;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            hb_cnt <= '0;
        end else if (state == S_RUN && next_state == S_RUN) begin
            hb_cnt <= hb_cnt + HB_DIV_LOG2'(1);
        end else begin
            hb_cnt <= '0;
        end
    end

    assign led_heartbeat = hb_cnt[HB_DIV_LOG2-1];
`else
    assign led_heartbeat = seq_done;
`endif

endmodule

// File: tb/tb_ndp_reset_sequencer.sv
// Bench for ndp_reset_sequencer: directed vector table, heartbeat run,
// then random pin activity against a time-since-lock reference model.
module tb_ndp_reset_sequencer;

    localparam int H  = 8;
    localparam int G  = 4;
    localparam int HB = 4;

    logic clk = 1'b0;
    logic rstn;
    logic lk;
    logic lu;
    logic sw;
    logic reg_resetn;
    logic core_resetn;
    logic dp_resetn;
    logic seq_done;
    logic led_heartbeat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ndp_reset_sequencer #(
        .HOLD_CYCLES(H),
        .STAGE_GAP  (G),
        .HB_DIV_LOG2(HB)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rstn),
        .clk_locked   (lk),
        .pcie_link_up (lu),
        .sw_reset_req (sw),
        .reg_resetn   (reg_resetn),
        .core_resetn  (core_resetn),
        .dp_resetn    (dp_resetn),
        .seq_done     (seq_done),
        .led_heartbeat(led_heartbeat)
    );

    typedef struct {
        int       n;
        bit       r;
        bit       l;
        bit       u;
        bit       s;
        bit [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: edges elapsed since the idle state accepted lock
    int since;
    bit pa0, pa1, pb0, pb1;

    function automatic vec_t mk(int n, bit r, bit l, bit u, bit s, bit [3:0] e);
        vec_t v;
        v.n = n; v.r = r; v.l = l; v.u = u; v.s = s; v.exp = e;
        return v;
    endfunction

    function automatic bit led_exp(bit done, int run_edges);
`ifdef NDP_RST_SEQ_HEARTBEAT_EN
        return done && ((run_edges % (1 << HB)) >= (1 << (HB - 1)));
`else
        return done;
`endif
    endfunction

    function automatic bit [4:0] model_out();
        bit r, c, d;
        r = since >= H;
        c = since >= H + G;
        d = since >= H + 2 * G;
        return {r, c, d, d, led_exp(d, since - (H + 2 * G))};
    endfunction

    task automatic model_step(input bit r, input bit l, input bit u, input bit s);
        bit lock;
        if (!r) begin
            pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
            since = -1;
        end else begin
            lock = pa1 & pb1;
            pa1 = pa0; pa0 = l;
            pb1 = pb0; pb0 = u;
            if (since < 0) begin
                if (lock) since = 0;
            end else if (!lock || s) begin
                since = -1;
            end else begin
                since++;
            end
        end
    endtask

    task automatic check(input string name, input bit [4:0] exp);
        bit [4:0] act;
        act = {reg_resetn, core_resetn, dp_resetn, seq_done, led_heartbeat};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b (reg,core,dp,done,led)",
                     name, $time, act, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; lk = 1'b1; lu = 1'b1; sw = 1'b0;

        // power-up: T0 is the 3rd edge after release
        tbl.push_back(mk(10, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(10, 1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1111));
        // one-cycle lock loss: resets drop three edges later, then restart
        tbl.push_back(mk(1,  1, 0, 1, 0, 4'b1111));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1111));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(8,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1111));
        // soft reset from RUN, then again in REL_CORE
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(8,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(8,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1111));
        // abort to IDLE, then a request seen in IDLE is ignored
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(7,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        // abort in REL_REG, then abort on the last HOLD cycle
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(7,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 1, 4'b0000));
        tbl.push_back(mk(8,  1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        // axis_resetn pulse in REL_REG, then power-up timing again
        tbl.push_back(mk(1,  0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(10, 1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(3,  1, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(1,  1, 1, 1, 0, 4'b1111));

        foreach (tbl[i]) begin
            rstn = tbl[i].r; lk = tbl[i].l; lu = tbl[i].u; sw = tbl[i].s;
            for (int j = 0; j < tbl[i].n; j++) begin
                @(posedge clk);
                #1;
                // Every table row sits within the first few RUN cycles
                check($sformatf("vec%0d.%0d", i, j),
                      {tbl[i].exp, led_exp(tbl[i].exp[0], 0)});
            end
        end

        // Heartbeat: RUN was entered on the last table edge
        rstn = 1'b1; lk = 1'b1; lu = 1'b1; sw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hb%0d", k), {4'b1111, led_exp(1'b1, k)});
        end

        // Random pin activity against the reference model
        since = -1; pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
        for (int i = 0; i < 4000; i++) begin
            rstn = (i < 2) ? 1'b0 : ($urandom_range(249) != 0);
            if (lk) lk = ($urandom_range(79) != 0);
            else    lk = ($urandom_range(3) == 0);
            if (lu) lu = ($urandom_range(119) != 0);
            else    lu = ($urandom_range(3) == 0);
            sw = ($urandom_range(39) == 0);
            @(posedge clk);
            model_step(rstn, lk, lu, sw);
            #1;
            check($sformatf("rnd%0d", i), model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
